axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
AXI4 slave memory model: the responder at the far end of the cache's AXI master port.
- Provides a word-addressed, byte-strobed RAM behind independent read and write channel FSMs.
- Used as the bench/backing memory for the MMU and cache, with one outstanding read and one outstanding write at a time.
- Read and write paths run concurrently.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
C_S_AXI_ADDR_WIDTH, 32, byte address width
C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
C_MEM_WORDS, 1024, RAM depth in 32-bit words (power of two)

Ports:
S_AXI_ACLK  in  1  clock, all logic rising-edge
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address channel
S_AXI_AWVALID  in  1 ; S_AXI_AWREADY  out  1
S_AXI_WDATA/WSTRB/WLAST  in  32/4/1  write data channel
S_AXI_WVALID  in  1 ; S_AXI_WREADY  out  1
S_AXI_BID/BRESP  out  ID/2 ; S_AXI_BVALID  out  1 ; S_AXI_BREADY  in  1
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address channel
S_AXI_ARVALID  in  1 ; S_AXI_ARREADY  out  1
S_AXI_RID/RDATA/RRESP/RLAST  out  ID/32/2/1 ; S_AXI_RVALID  out  1 ; S_AXI_RREADY  in  1
- Master LOCK/CACHE/PROT/QOS/USER outputs are not consumed and are left open at integration.

Behaviour:
- Reset (async assert, sync release):
  - AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0; BRESP/RRESP=0; BID/RID/RDATA=0.
  - FSMs go to IDLE; RAM contents are not cleared.
  - Reset mid-burst abandons the transaction silently; the first cycle after release is IDLE with READY=1.
- Word index = addr[log2(C_MEM_WORDS)+1:2]. addr[1:0] is ignored (treated as aligned).
- Address out of range (addr>>2 >= C_MEM_WORDS): write beat dropped, read beat returns 0, response SLVERR (2'b10).
- Per-beat address step:
  - INCR: +4.
  - FIXED: +0.
  - WRAP: treated as INCR.
  - Reserved burst 2'b11: treated as INCR with response SLVERR.
- AxSIZE != 3'b010: beats processed as 4-byte, response SLVERR.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch id/addr/len/burst, clear error flag, go W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes bytes whose WSTRB bit is 1, advances the address, and decrements the beat count.
  - W_DATA exit: after the (AWLEN+1)th beat, go W_RESP. If WLAST does not match the final beat (early or missing), set SLVERR; the burst length is always AWLEN+1 beats.
  - W_RESP: BVALID=1, BID=latched id, BRESP=OKAY(00) or SLVERR. Hold until BREADY, then go W_IDLE.
  - Minimum per single beat: AW hs at cycle N, WREADY at N+1, BVALID at the cycle after the W hs.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch the request, register RDATA=mem[addr], RVALID=1 in the next cycle (latency 1), RLAST=(ARLEN==0).
  - R_DATA: outputs held stable while RVALID&!RREADY.
  - On RVALID&RREADY with !RLAST: load the next beat in the same edge, so back-to-back beats come at 1 beat/cycle.
  - On RVALID&RREADY with RLAST: RVALID=0, go R_IDLE.
  - RRESP is per beat.
- Simultaneous write and read of the same word in one cycle: the read gets the old data (read-before-write).
- AW and AR accepted in the same cycle: both proceed independently.
- Beat counter is 9 bits, so AWLEN=255 gives 256 beats without wrap. Address arithmetic wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package axi_pkg holds:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR
  - burst enum FIXED/INCR/WRAP
  - wr_state_t / rd_state_t enums
  - SIZE_4B constant
- One sub-module, axi_mem_array: C_MEM_WORDS x 32 RAM with one byte-strobed write port and one registered read port (read-before-write).

Test Plan:
- Single write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF, then read ARADDR=0x10, ARLEN=0 -> BRESP=00; RDATA=0xDEADBEEF, RLAST=1, RRESP=00, RVALID one cycle after AR hs.
- Partial strobe: preload 0x11223344 at 0x20, write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
- INCR burst AWLEN=3 at 0x100 with data 1,2,3,4, then read ARLEN=3 with RREADY toggling 1,0,1,0 -> 4 beats 1,2,3,4; data stable during stalls; RLAST only on beat 4.
- Out-of-range ARADDR=C_MEM_WORDS*4 -> RRESP=10, RDATA=0. Write to the same address -> BRESP=10, memory unchanged.
- WLAST asserted on beat 2 of an AWLEN=3 burst -> 4 beats still accepted, BRESP=10. BVALID held while BREADY=0 for 5 cycles.
- Assert S_AXI_ARESETN=0 mid-read burst (beat 2 of 4) -> RVALID=0 immediately. After release ARREADY=1 and memory contents intact.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the slave memory model: response codes, burst
// encodings, channel FSM states and small per-beat helpers.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // WRAP and the reserved encoding both walk the address like INCR.
  function automatic logic [2:0] addr_step(input logic [1:0] burst);
    logic [2:0] step;
    case (burst)
      2'(BURST_FIXED): step = 3'd0;
      2'(BURST_INCR):  step = 3'd4;
      2'(BURST_WRAP):  step = 3'd4;
      default:         step = 3'd4;
    endcase
    return step;
  endfunction

  function automatic logic hdr_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_4B) || (burst == 2'b11);
  endfunction

  function automatic logic [1:0] beat_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word RAM with one byte-strobed write port and one registered read port;
// a read and write of the same word in one cycle returns the old contents.
module axi_mem_array #(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic             rclr,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q, rdata_d;

  // Storage is never reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data only moves when a new beat is requested; rclr forces zero.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rclr ? 32'd0 : mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backing memory: independent write (AW/W/B) and read (AR/R)
// FSMs, one outstanding transaction per direction, all outputs registered.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_WORDS        = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IDX_W = $clog2(C_MEM_WORDS);
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IW    = C_S_AXI_ID_WIDTH;

  function automatic logic out_of_range(input logic [AW-1:0] addr);
    return addr[AW-1:IDX_W+2] != '0;
  endfunction

  wr_state_t     wr_state_q, wr_state_d;
  logic [IW-1:0] awid_q, awid_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [1:0]    wburst_q, wburst_d;
  logic [8:0]    wcnt_q, wcnt_d;
  logic          werr_q, werr_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          mem_we_s, wbeat_err_s;

  rd_state_t     rd_state_q, rd_state_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [1:0]    rburst_q, rburst_d;
  logic [8:0]    rcnt_q, rcnt_d;
  logic          rerr_q, rerr_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          mem_re_s, mem_rclr_s;
  logic [AW-1:0] mem_raddr_s;

  // Write channel: accept AW, take exactly AWLEN+1 beats, then answer on B.
  always_comb begin
    wr_state_d  = wr_state_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    wburst_d    = wburst_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    bresp_d     = bresp_q;
    mem_we_s    = 1'b0;
    wbeat_err_s = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          awid_d     = S_AXI_AWID;
          waddr_d    = S_AXI_AWADDR;
          wburst_d   = S_AXI_AWBURST;
          wcnt_d     = {1'b0, S_AXI_AWLEN} + 9'd1;
          werr_d     = hdr_err(S_AXI_AWSIZE, S_AXI_AWBURST);
          wr_state_d = W_DATA;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          mem_we_s    = !out_of_range(waddr_q);
          wbeat_err_s = out_of_range(waddr_q) || (S_AXI_WLAST != (wcnt_q == 9'd1));
          waddr_d     = waddr_q + AW'(addr_step(wburst_q));
          wcnt_d      = wcnt_q - 9'd1;
          werr_d      = werr_q || wbeat_err_s;
          if (wcnt_q == 9'd1) begin
            bresp_d    = beat_resp(werr_q || wbeat_err_s);
            wr_state_d = W_RESP;
          end else begin
            wr_state_d = W_DATA;
          end
        end else begin
          wr_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE);
    wready_d  = (wr_state_d == W_DATA);
    bvalid_d  = (wr_state_d == W_RESP);
  end

  // Read channel: each accepted beat launches the next RAM read on the same edge.
  always_comb begin
    rd_state_d  = rd_state_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    rburst_d    = rburst_q;
    rcnt_d      = rcnt_q;
    rerr_d      = rerr_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    mem_re_s    = 1'b0;
    mem_rclr_s  = 1'b0;
    mem_raddr_s = raddr_q;
    case (rd_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          mem_re_s    = 1'b1;
          mem_raddr_s = S_AXI_ARADDR;
          mem_rclr_s  = out_of_range(S_AXI_ARADDR);
          rid_d       = S_AXI_ARID;
          rburst_d    = S_AXI_ARBURST;
          rerr_d      = hdr_err(S_AXI_ARSIZE, S_AXI_ARBURST);
          rresp_d     = beat_resp(hdr_err(S_AXI_ARSIZE, S_AXI_ARBURST) ||
                                  out_of_range(S_AXI_ARADDR));
          raddr_d     = S_AXI_ARADDR + AW'(addr_step(S_AXI_ARBURST));
          rcnt_d      = {1'b0, S_AXI_ARLEN};
          rlast_d     = (S_AXI_ARLEN == 8'd0);
          rvalid_d    = 1'b1;
          rd_state_d  = R_DATA;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rvalid_q && S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            rd_state_d = R_IDLE;
          end else begin
            mem_re_s   = 1'b1;
            mem_rclr_s = out_of_range(raddr_q);
            rresp_d    = beat_resp(rerr_q || out_of_range(raddr_q));
            raddr_d    = raddr_q + AW'(addr_step(rburst_q));
            rcnt_d     = rcnt_q - 9'd1;
            rlast_d    = (rcnt_q == 9'd1);
            rd_state_d = R_DATA;
          end
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // State and registered channel outputs for both directions.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      awid_q     <= '0;
      waddr_q    <= '0;
      wburst_q   <= 2'b00;
      wcnt_q     <= 9'd0;
      werr_q     <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      raddr_q    <= '0;
      rburst_q   <= 2'b00;
      rcnt_q     <= 9'd0;
      rerr_q     <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      awid_q     <= awid_d;
      waddr_q    <= waddr_d;
      wburst_q   <= wburst_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rburst_q   <= rburst_d;
      rcnt_q     <= rcnt_d;
      rerr_q     <= rerr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
    end
  end

  axi_mem_array #(
    .WORDS (C_MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .we    (mem_we_s),
    .waddr (waddr_q[IDX_W+1:2]),
    .wstrb (S_AXI_WSTRB),
    .wdata (S_AXI_WDATA),
    .re    (mem_re_s),
    .rclr  (mem_rclr_s),
    .raddr (mem_raddr_s[IDX_W+1:2]),
    .rdata (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BID     = awid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: single-beat vector table plus burst,
// WLAST-error, backpressure and mid-burst reset sequences, scored via queues.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awid, awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bid, bvalid, bready;
  logic [1:0]  bresp;
  logic        arid, arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rid, rlast, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  axi_slave_mem dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  wsize;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  vec_t        vecs[7];
  rexp_t       rq[$];
  logic [2:0]  bq[$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_v = 1'b0;
  logic [34:0] stall_val = 35'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard monitor: samples mid-cycle, pops expectations on each handshake.
  always @(negedge clk) begin
    rexp_t e;
    logic [2:0] be;
    if (!rst_n) begin
      stall_v <= 1'b0;
    end else begin
      if (stall_v)
        chk("r_stable", 64'({rvalid, rdata, rlast, rresp}), 64'({1'b1, stall_val}));
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          timeout("r_unexpected_beat");
        end else begin
          e = rq.pop_front();
          chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'({e.id, e.data, e.resp, e.last}));
        end
      end
      stall_v   <= rvalid && !rready;
      stall_val <= {rdata, rlast, rresp};
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          timeout("b_unexpected");
        end else begin
          be = bq.pop_front();
          chk("b_resp", 64'({bid, bresp}), 64'(be));
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [31:0] base, input logic [3:0] strb,
                          input int last_at, input int hold, input logic [1:0] exp_resp);
    bit ok;
    int lat = (last_at < 0) ? int'(len) : last_at;
    bq.push_back({1'b1, exp_resp});
    @(posedge clk); #1;
    awvalid = 1'b1; awid = 1'b1; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("wready_after_aw", 64'(wready), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = base + 32'(b); wstrb = strb; wlast = (b == lat);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (wready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("w_handshake");
    end
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("bvalid_latency", 64'(bvalid), 64'd1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bvalid_held", 64'(bvalid), 64'd1);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("b_response");
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Caller pushes expected beats to rq first.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input bit toggle);
    bit ok;
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_latency", 64'(rvalid), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rready = toggle ? (i % 2 == 0) : 1'b1;
      @(negedge clk); #1;
      if (rq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("r_beats");
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic push_beats(input logic [31:0] base, input int n, input bit incr, input logic [1:0] resp);
    for (int i = 0; i < n; i++)
      rq.push_back('{1'b1, incr ? base + 32'(i) : base, resp, (i == n - 1)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    awid = 1'b0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 1'b0; araddr = 32'd0; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;

    vecs[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF,    3'b010, 2'b00, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{1'b1, 32'h20,   32'h11223344, 4'hF,    3'b010, 2'b00, 32'h11223344, 2'b00};
    vecs[2] = '{1'b1, 32'h20,   32'hAABBCCDD, 4'b0101, 3'b010, 2'b00, 32'h11BB33DD, 2'b00};
    vecs[3] = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF,    3'b010, 2'b00, 32'hCAFEF00D, 2'b00};
    vecs[4] = '{1'b1, 32'h1000, 32'h12345678, 4'hF,    3'b010, 2'b10, 32'h00000000, 2'b10};
    vecs[5] = '{1'b0, 32'h0,    32'h0,        4'h0,    3'b010, 2'b00, 32'hCAFEF00D, 2'b00};
    vecs[6] = '{1'b1, 32'h43,   32'h55667788, 4'hF,    3'b001, 2'b10, 32'h55667788, 2'b00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'({awready, wready, arready}), 64'd0);
    chk("rst_valid", 64'({bvalid, rvalid, rlast}), 64'd0);
    chk("rst_resp_id", 64'({bresp, rresp, bid, rid}), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", 64'({awready, arready}), 64'b11);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_write)
        do_write(vecs[v].addr, 8'd0, 2'b01, vecs[v].wsize, vecs[v].wdata, vecs[v].wstrb, -1, 0,
                 vecs[v].exp_bresp);
      rq.push_back('{1'b1, vecs[v].exp_rdata, vecs[v].exp_rresp, 1'b1});
      do_read(vecs[v].addr, 8'd0, 2'b01, 3'b010, 1'b0);
    end

    // INCR burst with RREADY toggling 1,0,1,0.
    do_write(32'h100, 8'd3, 2'b01, 3'b010, 32'd1, 4'hF, -1, 0, 2'b00);
    push_beats(32'd1, 4, 1'b1, 2'b00);
    do_read(32'h100, 8'd3, 2'b01, 3'b010, 1'b1);

    // Early WLAST on beat 2 of 4: all beats still land, BRESP SLVERR, B held 5 cycles.
    do_write(32'h300, 8'd3, 2'b01, 3'b010, 32'hA0, 4'hF, 1, 5, 2'b10);
    push_beats(32'hA0, 4, 1'b1, 2'b00);
    do_read(32'h300, 8'd3, 2'b01, 3'b010, 1'b0);

    // FIXED burst: both beats hit one word; reads repeat it.
    do_write(32'h180, 8'd1, 2'b00, 3'b010, 32'h77, 4'hF, -1, 0, 2'b00);
    push_beats(32'h78, 2, 1'b0, 2'b00);
    do_read(32'h180, 8'd1, 2'b00, 3'b010, 1'b0);

    // Reserved burst encoding walks like INCR but flags every beat.
    push_beats(32'd1, 2, 1'b1, 2'b10);
    do_read(32'h100, 8'd1, 2'b11, 3'b010, 1'b0);

    // Reset during beat 2 of a 4-beat read.
    push_beats(32'd1, 4, 1'b1, 2'b00);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arsize = 3'b010;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("ar_handshake_rst");
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'({rvalid, rlast, arready}), 64'd0);
    chk("rst_mid_beats_seen", 64'(rq.size()), 64'd3);
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_arready", 64'(arready), 64'd1);
    push_beats(32'd1, 4, 1'b1, 2'b00);
    do_read(32'h100, 8'd3, 2'b01, 3'b010, 1'b0);

    chk("scoreboard_empty", 64'(rq.size() + bq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
